// File: rtl/cnn_mac_pkg.sv
// Shared types and signed-range helpers for the CNN multiply / multiply-accumulate pipe.
// Helpers work on a 64-bit signed carrier, so callers keep widths at 63 bits or less.
package cnn_mac_pkg;

    typedef enum logic {
        MAC_MODE_MUL = 1'b0,
        MAC_MODE_MAC = 1'b1
    } mac_mode_e;

    typedef struct packed {
        logic      valid;
        logic      first;
        logic      last;
        mac_mode_e mode;
    } mac_side_t;

    localparam int MAC_CALC_W = 64;

    // Clamp x to the two's-complement range of a 'width'-bit signed number.
    function automatic logic signed [MAC_CALC_W-1:0] sat_signed(
        input logic signed [MAC_CALC_W-1:0] x,
        input int unsigned                  width
    );
        logic signed [MAC_CALC_W-1:0] hi;
        logic signed [MAC_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic fits_signed(
        input logic signed [MAC_CALC_W-1:0] x,
        input int unsigned                  width
    );
        logic signed [MAC_CALC_W-1:0] hi;
        logic signed [MAC_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x <= hi) && (x >= lo);
    endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// NUM_STAGE-deep signed product pipe sharing one enable; plain multiply so the
// tools can fold the registers into a DSP slice.
module cnn_mac_mul_pipe #(
    parameter int NUM_STAGE = 3,
    parameter int A_WIDTH   = 14,
    parameter int B_WIDTH   = 9
) (
    input  logic                               clk,
    input  logic                               en,
    input  logic signed [A_WIDTH-1:0]          a,
    input  logic signed [B_WIDTH-1:0]          b,
    output logic signed [A_WIDTH+B_WIDTH-1:0]  p
);

    localparam int PW = A_WIDTH + B_WIDTH;

    logic signed [PW-1:0] prod_p [NUM_STAGE];

    // Data-only registers: no reset, validity travels in the caller's sideband pipe.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_p[0] <= PW'(a) * PW'(b);
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_p[i] <= prod_p[i-1];
            end
        end
    end

    assign p = prod_p[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe_ctl.sv
// Pipelined signed MUL / MAC unit with valid/ready flow control and overflow flag.
// Define CNN_MAC_SATURATE_EN to saturate the accumulator and clamp dout instead of wrapping.
module cnn_mac_pipe_ctl
    import cnn_mac_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 9,
    parameter int ACC_WIDTH  = 32,
    parameter int dout_WIDTH = 23
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [din0_WIDTH-1:0]  din0,
    input  logic signed [din1_WIDTH-1:0]  din1,
    input  logic                          acc_first,
    input  logic                          acc_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [dout_WIDTH-1:0]  dout,
    output logic                          ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    logic                         stall;
    logic                         adv;
    logic                         rdy_en;
    mac_side_t                    side_in;
    mac_side_t                    side_p [NUM_STAGE];
    mac_side_t                    side_pn;
    logic signed [PW-1:0]         prod_pn;
    logic                         is_first;
    logic                         is_last;
    logic signed [ACC_WIDTH-1:0]  acc_p;
    logic signed [ACC_WIDTH-1:0]  acc_nxt;
    logic signed [63:0]           nacc_w;
`ifdef CNN_MAC_SATURATE_EN
    logic signed [63:0]           sum_w;
`endif
    logic signed [dout_WIDTH-1:0] dout_nxt;
    logic                         ovf_nxt;

    // A held result freezes every stage at once, so nothing is dropped or duplicated.
    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = rdy_en & ~stall;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        side_in.valid = in_valid & in_ready;
        side_in.first = acc_first;
        side_in.last  = acc_last;
        side_in.mode  = mac_mode_e'(mode);
    end

    // ---- product stages p0 .. p(NUM_STAGE-1)
    cnn_mac_mul_pipe #(
        .NUM_STAGE (NUM_STAGE),
        .A_WIDTH   (din0_WIDTH),
        .B_WIDTH   (din1_WIDTH)
    ) u_mul (
        .clk (ap_clk),
        .en  (adv),
        .a   (din0),
        .b   (din1),
        .p   (prod_pn)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                side_p[i] <= '0;
            end
        end else if (adv) begin
            side_p[0] <= side_in;
            for (int i = 1; i < NUM_STAGE; i++) begin
                side_p[i] <= side_p[i-1];
            end
        end
    end

    assign side_pn = side_p[NUM_STAGE-1];

    // ---- accumulate / output stage
    always_comb begin
        is_first = side_pn.first | (side_pn.mode == MAC_MODE_MUL);
        is_last  = side_pn.last  | (side_pn.mode == MAC_MODE_MUL);
`ifdef CNN_MAC_SATURATE_EN
        sum_w = 64'(acc_p) + 64'(prod_pn);
        if (is_first) begin
            acc_nxt = ACC_WIDTH'(prod_pn);
        end else begin
            acc_nxt = ACC_WIDTH'(sat_signed(sum_w, ACC_WIDTH));
        end
        nacc_w   = 64'(acc_nxt);
        dout_nxt = dout_WIDTH'(sat_signed(nacc_w, dout_WIDTH));
`else
        if (is_first) begin
            acc_nxt = ACC_WIDTH'(prod_pn);
        end else begin
            acc_nxt = acc_p + ACC_WIDTH'(prod_pn);
        end
        nacc_w   = 64'(acc_nxt);
        dout_nxt = dout_WIDTH'(nacc_w);
`endif
        ovf_nxt = ~fits_signed(nacc_w, dout_WIDTH);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_p     <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= side_pn.valid & is_last;
            if (side_pn.valid) begin
                acc_p <= acc_nxt;
            end
            if (side_pn.valid & is_last) begin
                dout <= dout_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe_ctl.sv
// Self-checking bench: two instances (dout 23 and 16 bits) driven from shared
// inputs, each checked against its own arithmetic reference model.
module tb_cnn_mac_pipe_ctl;

    localparam int NS   = 3;
    localparam int AW   = 14;
    localparam int BW   = 9;
    localparam int DWA  = 23;
    localparam int DWB  = 16;

    logic                   ap_clk;
    logic                   ap_rst;
    logic                   mode;
    logic                   in_valid;
    logic                   acc_first;
    logic                   acc_last;
    logic                   out_ready;
    logic signed [AW-1:0]   din0;
    logic signed [BW-1:0]   din1;
    logic                   in_ready_a, in_ready_b;
    logic                   out_valid_a, out_valid_b;
    logic signed [DWA-1:0]  dout_a;
    logic signed [DWB-1:0]  dout_b;
    logic                   ovf_a, ovf_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_lat  = 0;

    typedef struct {
        longint d;
        logic   o;
        int     acyc;
    } exp_t;

    exp_t   qa[$];
    exp_t   qb[$];
    longint acc_m [2];

    cnn_mac_pipe_ctl #(.ID(1), .NUM_STAGE(NS), .din0_WIDTH(AW), .din1_WIDTH(BW),
                       .ACC_WIDTH(32), .dout_WIDTH(DWA)) u_dut_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready_a), .din0(din0), .din1(din1), .acc_first(acc_first),
        .acc_last(acc_last), .out_valid(out_valid_a), .out_ready(out_ready),
        .dout(dout_a), .ovf(ovf_a));

    cnn_mac_pipe_ctl #(.ID(2), .NUM_STAGE(NS), .din0_WIDTH(AW), .din1_WIDTH(BW),
                       .ACC_WIDTH(32), .dout_WIDTH(DWB)) u_dut_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready_b), .din0(din0), .din1(din1), .acc_first(acc_first),
        .acc_last(acc_last), .out_valid(out_valid_b), .out_ready(out_ready),
        .dout(dout_b), .ovf(ovf_b));

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // 32-bit accumulator arithmetic, wrapping or saturating.
    function automatic longint acc_add(input longint x);
`ifdef CNN_MAC_SATURATE_EN
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
`else
        return longint'(int'(x));
`endif
    endfunction

    function automatic void fmt(input longint acc, input int w, output longint d, output logic o);
        longint lim;
        longint r;
        lim = longint'(1) <<< (w - 1);
        o = (acc > lim - 1) || (acc < -lim);
`ifdef CNN_MAC_SATURATE_EN
        d = !o ? acc : (acc < 0 ? -lim : lim - 1);
`else
        r = acc & (2 * lim - 1);
        if (r >= lim) r = r - 2 * lim;
        d = r;
`endif
    endfunction

    task automatic model_accept(input int idx, input logic m, input logic f, input logic l,
                                input int a, input int b);
        longint p;
        exp_t   e;
        p = longint'(a) * longint'(b);
        if (m == 1'b0 || f) acc_m[idx] = p;
        else acc_m[idx] = acc_add(acc_m[idx] + p);
        if (m == 1'b0 || l) begin
            fmt(acc_m[idx], (idx == 0) ? DWA : DWB, e.d, e.o);
            e.acyc = cyc;
            if (idx == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic check_one(input int idx, input logic ov, input logic signed [63:0] d, input logic o);
        exp_t e;
        int   qs;
        if (ov === 1'b1) begin
            qs = (idx == 0) ? qa.size() : qb.size();
            n_checks++;
            assert (qs > 0) else begin
                n_fail++;
                $error("FAIL unexpected_out dut=%0d observed=out_valid expected=no_result", idx);
            end
            if (qs > 0) begin
                e = (idx == 0) ? qa[0] : qb[0];
                chk((idx == 0) ? "dout_a" : "dout_b", d, e.d);
                chk((idx == 0) ? "ovf_a" : "ovf_b", 64'(o), 64'(e.o));
                if (out_ready) begin
                    if (chk_lat) chk("latency", cyc - e.acyc, NS + 1);
                    if (idx == 0) void'(qa.pop_front());
                    else void'(qb.pop_front());
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic m, input logic f, input logic l,
                        input int a, input int b, input logic ordy, output logic acc_o);
        logic ra, rb;
        @(negedge ap_clk);
        in_valid  = v;
        mode      = m;
        acc_first = f;
        acc_last  = l;
        din0      = AW'(a);
        din1      = BW'(b);
        out_ready = ordy;
        #1;
        ra = in_ready_a;
        rb = in_ready_b;
        check_one(0, out_valid_a, 64'(dout_a), ovf_a);
        check_one(1, out_valid_b, 64'(dout_b), ovf_b);
        if (v && ra) model_accept(0, m, f, l, a, b);
        if (v && rb) model_accept(1, m, f, l, a, b);
        acc_o = v && ra;
        cyc++;
    endtask

    task automatic drain(input string tag);
        logic dmy;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 1, dmy);
        chk({tag, "_empty_a"}, qa.size(), 0);
        chk({tag, "_empty_b"}, qb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid_a"}, 64'(out_valid_a), 0);
        chk({tag, "_out_valid_b"}, 64'(out_valid_b), 0);
        chk({tag, "_dout_a"}, 64'(dout_a), 0);
        chk({tag, "_dout_b"}, 64'(dout_b), 0);
        chk({tag, "_ovf_a"}, 64'(ovf_a), 0);
        chk({tag, "_ovf_b"}, 64'(ovf_b), 0);
    endtask

    initial begin
        logic ok;
        int   sent;
        ap_rst = 1'b1; mode = 0; in_valid = 0; acc_first = 0; acc_last = 0;
        out_ready = 1; din0 = '0; din1 = '0;
        acc_m[0] = 0; acc_m[1] = 0;

        // Reset state, then in_ready after the first edge out of reset.
        repeat (2) @(negedge ap_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge ap_clk);
        ap_rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1, ok);
        chk("in_ready_a_post_rst", 64'(in_ready_a), 1);
        chk("in_ready_b_post_rst", 64'(in_ready_b), 1);

        // MUL with extreme operands, latency checked.
        chk_lat = 1;
        step(1, 0, 0, 0, -8192, -256, 1, ok);
        chk("mul_accepted", 64'(ok), 1);
        chk("mul_model_value", qa[0].d, 2097152);
        drain("mul");

        // MAC burst of three beats.
        step(1, 1, 1, 0, 100, 3, 1, ok);
        step(1, 1, 0, 0, -50, 2, 1, ok);
        step(1, 1, 0, 1, 7, -1, 1, ok);
        chk("mac3_model_value", qa[0].d, 193);
        drain("mac3");

        // Back-to-back MUL with out_ready low on cycles 3..6.
        chk_lat = 0;
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            step(1, 0, 0, 0, 1000 * sent - 3000, 17 * sent - 60, !(c >= 3 && c <= 6), ok);
            if (ok) sent++;
        end
        chk("bp_all_sent", sent, 8);
        drain("bp");

        // Overflow burst: 4 x (8191,255).
        chk_lat = 1;
        for (int i = 0; i < 4; i++) step(1, 1, (i == 0), (i == 3), 8191, 255, 1, ok);
        chk("ovf_model_b", 64'(qb[0].o), 1);
        drain("ovf");

        // Reset in the middle of a burst.
        step(1, 1, 1, 0, 3, 4, 1, ok);
        step(1, 1, 0, 0, 5, 6, 1, ok);
        @(negedge ap_clk);
        in_valid = 0;
        ap_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        qa.delete(); qb.delete();
        acc_m[0] = 0; acc_m[1] = 0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1, ok);
        chk("in_ready_after_midrst", 64'(in_ready_a), 1);
        step(1, 1, 1, 1, 5, 5, 1, ok);
        chk("midrst_model_value", qa[0].d, 25);
        drain("midrst");

        // Mode switch mid-burst drops the partial sum.
        step(1, 1, 1, 0, 10, 10, 1, ok);
        step(1, 0, 0, 0, 2, 3, 1, ok);
        chk("modesw_model_value", qa[0].d, 6);
        drain("modesw");

        // Randomised traffic with random backpressure.
        chk_lat = 0;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(3) == 0,
                 $urandom_range(3) == 0, int'($urandom_range(16383)) - 8192,
                 int'($urandom_range(511)) - 256, $urandom_range(3) != 0, ok);
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
